key_debounce_multi: RTL and testbench
=====================================

KEY_DEBOUNCE_MULTI -- requirements
Module: key_debounce_multi

Interface
REQ-001 Parameter N_KEYS, default 16: number of independent key channels, 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flip-flop depth per channel, 2..4.
REQ-003 Parameter DEBOUNCE_CYCLES, default 4: consecutive agreeing samples required to accept a level change, >=1.
REQ-004 Parameter EDGE_MODE, default EDGE_RISE: detection mode, one of EDGE_RISE, EDGE_FALL, EDGE_BOTH.
REQ-005 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-006 Port rst  input  1: reset, asynchronous, active-low.
REQ-007 Port key_press  input  N_KEYS: raw asynchronous key levels, 1 = pressed.
REQ-008 Port key_stable  output  N_KEYS: debounced key levels.
REQ-009 Port key_detect  output  N_KEYS: one-cycle per-channel edge pulses per EDGE_MODE.
REQ-010 Port key_valid  output  1: high in any cycle where key_detect is nonzero.
REQ-011 Port key_code  output  $clog2(N_KEYS) (min 1): index of the lowest-numbered set bit of key_detect; 0 when key_valid is low.
REQ-012 Port key_multi  output  1: high when more than one key_detect bit is set in the same cycle.

Function
REQ-013 Each channel SHALL pass key_press[i] through SYNC_STAGES flip-flops before any other use; the last stage is sync[i].
REQ-014 Each channel SHALL hold a counter of width $clog2(DEBOUNCE_CYCLES+1) that clears whenever sync[i] equals key_stable[i].
REQ-015 While sync[i] differs from key_stable[i], the counter SHALL increment each cycle; on the cycle it would reach DEBOUNCE_CYCLES, key_stable[i] SHALL take sync[i] and the counter SHALL clear.
REQ-016 A single disagreeing sample (bounce) SHALL clear the counter; the count restarts from zero.
REQ-017 A clean input change SHALL appear on key_stable exactly SYNC_STAGES + DEBOUNCE_CYCLES rising edges after the first edge that samples the new level.
REQ-018 key_detect[i] SHALL be registered and high for exactly the one cycle in which key_stable[i] shows its new value, qualified by EDGE_MODE: 0->1 for EDGE_RISE, 1->0 for EDGE_FALL, either for EDGE_BOTH.
REQ-019 A key held indefinitely SHALL produce exactly one detect pulse; no auto-repeat.
REQ-020 key_valid, key_code and key_multi SHALL be combinational from the key_detect registers, so all four outputs are cycle-aligned.
REQ-021 Simultaneous detects SHALL report the lowest index on key_code and assert key_multi; all set bits remain visible on key_detect.
REQ-022 Counters SHALL never wrap: after reaching DEBOUNCE_CYCLES the counter clears in the same update.
REQ-023 With DEBOUNCE_CYCLES = 1, key_stable SHALL follow sync with one cycle of delay.

Reset
REQ-024 Asserting rst low SHALL immediately clear all synchronizer stages, counters, key_stable and key_detect; key_valid, key_code and key_multi SHALL then read 0.
REQ-025 Reset asserted mid-debounce SHALL discard the partial count with no pulse emitted.
REQ-026 A key held high across reset release SHALL be treated as a new press and, in EDGE_RISE or EDGE_BOTH, produce one detect after the REQ-017 latency.

Structure
REQ-027 Package key_pkg SHALL hold the edge-mode constants EDGE_RISE = 0, EDGE_FALL = 1 and EDGE_BOTH = 2 and the default parameter values.
REQ-028 Per-channel logic (synchronizer, counter, stable register, detect register) SHALL be a sub-module key_debounce_chan, instantiated N_KEYS times by generate.
REQ-029 The priority encoder and multi-detect logic SHALL live in the top module.

Verification (N_KEYS=16, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, EDGE_MODE=EDGE_RISE unless noted)
REQ-030 Clean press: key_press[5] 0->1 held -> key_stable[5] rises 6 edges later; key_detect[5], key_valid=1 and key_code=5 for one cycle; nothing further while held.
REQ-031 Bounce: key_press[3] toggles 1,0,1,0 at 1-cycle spacing, then holds 1 -> no detect during the toggling; exactly one detect 6 edges after the final rise.
REQ-032 Simultaneous press: bits 2 and 9 rise on the same edge -> key_detect=0x0204, key_code=2, key_multi=1 for one cycle.
REQ-033 EDGE_BOTH on channel 0, press then release after 20 cycles -> two detect pulses, each 6 edges after its input change.
REQ-034 Reset mid-debounce: rst low 2 cycles after key_press[7] rises -> all outputs 0 at once; after release with the key still held, one detect 6 edges after the first post-reset sample.
REQ-035 DEBOUNCE_CYCLES=1, key_press[15] pulse 3 cycles wide -> rise and fall on key_stable[15], each at latency 3; one detect, key_code=15.

Source files
------------

// File: rtl/key_pkg.sv
// Shared constants for the multi-key debouncer.
//   EDGE_RISE / EDGE_FALL / EDGE_BOTH : values accepted by the EDGE_MODE parameter
//   DEF_*                             : default parameter values used by the top
package key_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  localparam int DEF_N_KEYS          = 16;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_EDGE_MODE       = EDGE_RISE;

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: synchronizer chain, debounce counter, stable level register
// and a registered edge-detect pulse.
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   key_in     : raw asynchronous key level (1 = pressed)
//   key_stable : debounced level
//   key_detect : one-cycle pulse, aligned with the key_stable update, filtered by EDGE_MODE
module key_debounce_chan
  import key_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int EDGE_MODE       = DEF_EDGE_MODE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_stable,
  output logic key_detect
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // The update happens on the cycle the counter would reach DEBOUNCE_CYCLES,
  // so the counter itself never holds that value and cannot wrap.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   detect_q, detect_d;
  logic                   sync_w;
  logic                   edge_hit;

  assign sync_w = sync_q[SYNC_STAGES-1];

  always_comb begin
    edge_hit = 1'b0;
    case (EDGE_MODE)
      EDGE_RISE: edge_hit = sync_w;
      EDGE_FALL: edge_hit = ~sync_w;
      default:   edge_hit = 1'b1;
    endcase
  end

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], key_in};
    stable_d = stable_q;
    cnt_d    = '0;
    detect_d = 1'b0;
    if (sync_w != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_w;
        detect_d = edge_hit;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      detect_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      detect_q <= detect_d;
    end
  end

  assign key_stable = stable_q;
  assign key_detect = detect_q;

endmodule

// File: rtl/key_debounce_multi.sv
// N_KEYS independent debounced key channels plus a priority encoder over the
// registered detect pulses.
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset
//   key_press  : raw key levels, 1 = pressed
//   key_stable : debounced levels
//   key_detect : per-channel one-cycle edge pulses
//   key_valid  : any key_detect bit set
//   key_code   : lowest set key_detect index, 0 when none
//   key_multi  : more than one key_detect bit set
module key_debounce_multi
  import key_pkg::*;
#(
  parameter int N_KEYS          = DEF_N_KEYS,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int EDGE_MODE       = DEF_EDGE_MODE
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [N_KEYS-1:0]                             key_press,
  output logic [N_KEYS-1:0]                             key_stable,
  output logic [N_KEYS-1:0]                             key_detect,
  output logic                                          key_valid,
  output logic [((N_KEYS > 1) ? $clog2(N_KEYS) : 1)-1:0] key_code,
  output logic                                          key_multi
);

  localparam int CODE_W = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    key_debounce_chan #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .EDGE_MODE       (EDGE_MODE)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst),
      .key_in     (key_press[i]),
      .key_stable (key_stable[i]),
      .key_detect (key_detect[i])
    );
  end

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    key_code = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (key_detect[i]) key_code = CODE_W'(i);
    end
  end

  assign key_valid = |key_detect;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign key_multi = |(key_detect & (key_detect - N_KEYS'(1)));

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi: three instances (default EDGE_RISE,
// EDGE_BOTH, DEBOUNCE_CYCLES=1) sharing clock and reset.
module tb_key_debounce_multi;
  import key_pkg::*;

  logic clk;
  logic rst;

  logic [15:0] kp_r, st_r, det_r;
  logic        val_r, mul_r;
  logic [3:0]  code_r;

  logic [15:0] kp_b, st_b, det_b;
  logic        val_b, mul_b;
  logic [3:0]  code_b;

  logic [15:0] kp_d, st_d, det_d;
  logic        val_d, mul_d;
  logic [3:0]  code_d;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] acc;

  key_debounce_multi #(.N_KEYS(16), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(EDGE_RISE)) dut (
    .clk(clk), .rst(rst), .key_press(kp_r), .key_stable(st_r), .key_detect(det_r),
    .key_valid(val_r), .key_code(code_r), .key_multi(mul_r));

  key_debounce_multi #(.N_KEYS(16), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(EDGE_BOTH)) dut_both (
    .clk(clk), .rst(rst), .key_press(kp_b), .key_stable(st_b), .key_detect(det_b),
    .key_valid(val_b), .key_code(code_b), .key_multi(mul_b));

  key_debounce_multi #(.N_KEYS(16), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .EDGE_MODE(EDGE_RISE)) dut_d1 (
    .clk(clk), .rst(rst), .key_press(kp_d), .key_stable(st_d), .key_detect(det_d),
    .key_valid(val_d), .key_code(code_d), .key_multi(mul_d));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance n edges, OR-ing every observed detect vector of the default DUT into acc.
  task automatic ticks_acc(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      acc = acc | det_r;
    end
  endtask

  initial begin
    rst  = 1'b0;
    kp_r = '0;
    kp_b = '0;
    kp_d = '0;
    ticks(3);
    check_eq("reset_stable", {16'h0, st_r}, 32'h0);
    check_eq("reset_outs", {det_r, 11'h0, val_r, code_r, mul_r}, 32'h0);
    rst = 1'b1;
    ticks(3);

    // Clean press on channel 5
    kp_r[5] = 1'b1;
    ticks(5);
    check_eq("press_pre_stable", {31'h0, st_r[5]}, 32'h0);
    check_eq("press_pre_detect", {16'h0, det_r}, 32'h0);
    tick();
    check_eq("press_stable", {31'h0, st_r[5]}, 32'h1);
    check_eq("press_detect", {16'h0, det_r}, 32'h0020);
    check_eq("press_valid_code_multi", {26'h0, val_r, code_r, mul_r}, {26'h0, 1'b1, 4'd5, 1'b0});
    tick();
    check_eq("press_pulse_end", {16'h0, det_r}, 32'h0);
    check_eq("press_idle_outs", {26'h0, val_r, code_r, mul_r}, 32'h0);
    acc = '0;
    ticks_acc(20);
    check_eq("hold_no_repeat", {16'h0, acc}, 32'h0);
    kp_r[5] = 1'b0;
    acc = '0;
    ticks_acc(10);
    check_eq("release_rise_mode_no_detect", {16'h0, acc}, 32'h0);
    check_eq("release_stable", {31'h0, st_r[5]}, 32'h0);

    // Bounce on channel 3: 1,0,1,0 then hold 1
    acc = '0;
    kp_r[3] = 1'b1; ticks_acc(1);
    kp_r[3] = 1'b0; ticks_acc(1);
    kp_r[3] = 1'b1; ticks_acc(1);
    kp_r[3] = 1'b0; ticks_acc(1);
    kp_r[3] = 1'b1;
    ticks_acc(5);
    check_eq("bounce_no_detect", {16'h0, acc}, 32'h0);
    check_eq("bounce_pre_stable", {31'h0, st_r[3]}, 32'h0);
    tick();
    check_eq("bounce_detect", {16'h0, det_r}, 32'h0008);
    check_eq("bounce_code", {28'h0, code_r}, 32'd3);
    acc = '0;
    ticks_acc(10);
    check_eq("bounce_single_pulse", {16'h0, acc}, 32'h0);
    kp_r[3] = 1'b0;
    ticks(12);

    // Simultaneous press on channels 2 and 9
    kp_r[2] = 1'b1;
    kp_r[9] = 1'b1;
    ticks(6);
    check_eq("multi_detect", {16'h0, det_r}, 32'h0204);
    check_eq("multi_valid_code_multi", {26'h0, val_r, code_r, mul_r}, {26'h0, 1'b1, 4'd2, 1'b1});
    tick();
    check_eq("multi_pulse_end", {26'h0, val_r, code_r, mul_r}, 32'h0);
    kp_r[2] = 1'b0;
    kp_r[9] = 1'b0;
    ticks(12);

    // EDGE_BOTH on channel 0: press, release 20 cycles later
    kp_b[0] = 1'b1;
    ticks(5);
    check_eq("both_press_pre", {16'h0, det_b}, 32'h0);
    tick();
    check_eq("both_press_detect", {16'h0, det_b}, 32'h0001);
    check_eq("both_press_valid_code", {27'h0, val_b, code_b}, {27'h0, 1'b1, 4'd0});
    tick();
    check_eq("both_press_end", {16'h0, det_b}, 32'h0);
    ticks(13);
    kp_b[0] = 1'b0;
    ticks(5);
    check_eq("both_release_pre", {15'h0, st_b[0], det_b}, {15'h0, 1'b1, 16'h0});
    tick();
    check_eq("both_release_detect", {15'h0, st_b[0], det_b}, {15'h0, 1'b0, 16'h0001});
    tick();
    check_eq("both_release_end", {16'h0, det_b}, 32'h0);

    // DEBOUNCE_CYCLES = 1, 3-cycle pulse on channel 15
    kp_d[15] = 1'b1;
    ticks(2);
    check_eq("d1_rise_pre", {31'h0, st_d[15]}, 32'h0);
    tick();
    check_eq("d1_rise_stable", {31'h0, st_d[15]}, 32'h1);
    check_eq("d1_detect", {16'h0, det_d}, 32'h8000);
    check_eq("d1_valid_code", {27'h0, val_d, code_d}, {27'h0, 1'b1, 4'd15});
    kp_d[15] = 1'b0;
    tick();
    check_eq("d1_detect_end", {31'h0, st_d[15]} | {15'h0, det_d, 1'b0}, 32'h1);
    tick();
    check_eq("d1_fall_pre", {31'h0, st_d[15]}, 32'h1);
    tick();
    check_eq("d1_fall_stable", {15'h0, st_d[15], det_d}, 32'h0);

    // Reset mid-debounce on channel 7, channel 10 already stable-high
    kp_r[10] = 1'b1;
    ticks(8);
    check_eq("pre_reset_stable", {16'h0, st_r}, 32'h0400);
    kp_r[7] = 1'b1;
    ticks(2);
    rst = 1'b0;
    #1;
    check_eq("async_reset_stable", {16'h0, st_r}, 32'h0);
    check_eq("async_reset_outs", {det_r, 11'h0, val_r, code_r, mul_r}, 32'h0);
    ticks(2);
    check_eq("reset_no_pulse", {16'h0, det_r}, 32'h0);
    rst = 1'b1;
    acc = '0;
    ticks_acc(5);
    check_eq("post_reset_pre", {16'h0, acc}, 32'h0);
    tick();
    check_eq("post_reset_detect", {16'h0, det_r}, 32'h0480);
    check_eq("post_reset_code_multi", {26'h0, val_r, code_r, mul_r}, {26'h0, 1'b1, 4'd7, 1'b1});
    tick();
    check_eq("post_reset_end", {16'h0, det_r}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
